pixel_stream_arbiter: RTL and testbench
=======================================

# pixel_stream_arbiter

Parametrised successor to the camera-path arbitrator: selects one of an RGB source or NUM_GRAY single-channel sources, formats each accepted pixel into 2×PIX_W-bit words, and buffers them in per-port FIFOs feeding the two SDRAM write ports. Unlike its predecessor, it has:
- backpressure on both write ports;
- mode changes only at frame boundaries;
- sticky overflow flags;
- an optional packed-gray mode.

## Interface
- PIX_W, 8, pixel component width; output words are 2*PIX_W bits
- NUM_GRAY, 2, number of gray sources (1..6)
- FIFO_DEPTH, 4, per-port FIFO depth, power of two ≥ 2
- SEL_W, 3, select width
- iClk  in  1  clock; all logic on rising edge
- iRst_n  in  1  synchronous active-low reset
- iSelect  in  SEL_W  requested mode: 0 idle, 1 RGB, 2..NUM_GRAY+1 gray source (iSelect-2), others idle
- iFrame_start  in  1  frame-boundary pulse; loads active mode from iSelect
- iRGB_valid  in  1  RGB pixel valid
- iRGB_R, iRGB_G, iRGB_B  in  PIX_W each  RGB components
- iGray_valid  in  NUM_GRAY  per-source valid
- iGray  in  NUM_GRAY*PIX_W  source k at bits [k*PIX_W +: PIX_W]
- iWr1_ready, iWr2_ready  in  1 each  write port accepts head word
- iClear_ovf  in  1  clears oOverflow
- oWr1_valid, oWr2_valid  out  1 each  head word valid
- oWr1_data, oWr2_data  out  2*PIX_W each  head word
- oMode  out  SEL_W  active mode
- oOverflow  out  2  sticky drop flag, bit0 port1, bit1 port2

## Operation
**Mode selection**
- Effective mode is iSelect in a cycle with iFrame_start=1, else oMode. oMode loads iSelect at that edge.
- Input pixels are accepted only from the source matching the effective mode. All other valids are ignored.

**Word formatting**
- RGB: wr1 = {R,G}, wr2 = {B, PIX_W'b0}.
- Gray (unpacked): wr1 = wr2 = {g,g}.

**Buffering and handshake**
- Each accepted word is pushed into its port FIFO.
- A port pops when oWrN_valid && iWrN_ready.
- Push and pop in the same cycle on a full FIFO: both occur, occupancy unchanged.
- Push on a full FIFO with no pop: the word is dropped for that port only. The other port still pushes. oOverflow[port] is set.
- oOverflow clears only on iClear_ovf or reset. A set event in the same cycle as iClear_ovf wins.
- A mode change does not flush the FIFOs. Queued words drain in order.
- Idle mode pushes nothing.

**Reset**
- Empties both FIFOs and clears the pack phase.
- Outputs after reset: oMode=0, oOverflow=0, oWr*_valid=0, oWr*_data=0.

## Timing
- Latency: a pixel accepted in cycle N gives oWrN_valid=1 with its data in cycle N+1 when that FIFO was empty.
- Each FIFO accepts one push and one pop per cycle. Throughput is one word per port per cycle with ready held high.
- oWrN_data is stable while oWrN_valid=1 and iWrN_ready=0.
- oMode changes the edge after iFrame_start. The pixel in the iFrame_start cycle already uses the new mode.
- Reset asserted mid-stream discards all queued words at the next edge.

## Configuration
Macro ARB_GRAY_PACK_EN selects gray-mode packing.

**Defined:**
- Gray modes pack two consecutive accepted pixels p0, p1 into wr1 = {p1,p0}. The word is pushed on acceptance of p1. Port 2 receives nothing.
- A pack-phase bit tracks pairing. iFrame_start clears it, so the pixel in that cycle becomes p0. An unpaired trailing pixel is discarded.
- RGB mode is unchanged.

**Undefined:**
- Unpacked gray as above. No pack-phase logic is built.

## Test plan
- Reset, then inputs toggling with iRst_n=0 → oMode=0, oWr*_valid=0, oOverflow=0 for every cycle of reset.
- iFrame_start with iSelect=1, R=G=B=255, ready=1 → next cycle oWr1_data=16'hFFFF, oWr2_data=16'hFF00, both valid. Then R=100 with iRGB_valid=0 → no word pushed.
- Mode 1 active; iSelect=2 with gray valid, iFrame_start=0 → no gray words. Pulse iFrame_start → gray 0x5A yields 16'h5A5A on both ports from that cycle's pixel.
- Mode 1, iWr2_ready=0, iWr1_ready=1, FIFO_DEPTH+1 RGB pixels → port1 passes all words, port2 holds 4 words, oOverflow=2'b10. iClear_ovf → 2'b00.
- Mode 1 with port 2 full; pop and push in the same cycle → no overflow, and port 2 words emerge in order when ready returns.
- ARB_GRAY_PACK_EN, mode 2, pixels 0x11, 0x22, 0x33, then iFrame_start with 0x44, 0x55 → wr1 words 16'h2211 then 16'h5544. 0x33 is dropped and oWr2_valid never rises.

Source files
------------

// File: rtl/pixel_stream_arbiter_if.sv
// Pixel stream arbiter bus: source select, RGB/gray pixel inputs,
// and the two valid/ready SDRAM write ports.
interface pixel_stream_arbiter_if #(
   parameter int PIX_W    = 8,
   parameter int NUM_GRAY = 2,
   parameter int SEL_W    = 3
);
   logic [SEL_W-1:0]          iSelect;
   logic                      iFrame_start;
   logic                      iRGB_valid;
   logic [PIX_W-1:0]          iRGB_R;
   logic [PIX_W-1:0]          iRGB_G;
   logic [PIX_W-1:0]          iRGB_B;
   logic [NUM_GRAY-1:0]       iGray_valid;
   logic [NUM_GRAY*PIX_W-1:0] iGray;
   logic                      iWr1_ready;
   logic                      iWr2_ready;
   logic                      iClear_ovf;
   logic                      oWr1_valid;
   logic                      oWr2_valid;
   logic [2*PIX_W-1:0]        oWr1_data;
   logic [2*PIX_W-1:0]        oWr2_data;
   logic [SEL_W-1:0]          oMode;
   logic [1:0]                oOverflow;

   modport master (
      output iSelect, iFrame_start,
      output iRGB_valid, iRGB_R, iRGB_G, iRGB_B,
      output iGray_valid, iGray,
      output iWr1_ready, iWr2_ready, iClear_ovf,
      input  oWr1_valid, oWr2_valid,
      input  oWr1_data, oWr2_data,
      input  oMode, oOverflow
   );

   modport slave (
      input  iSelect, iFrame_start,
      input  iRGB_valid, iRGB_R, iRGB_G, iRGB_B,
      input  iGray_valid, iGray,
      input  iWr1_ready, iWr2_ready, iClear_ovf,
      output oWr1_valid, oWr2_valid,
      output oWr1_data, oWr2_data,
      output oMode, oOverflow
   );
endinterface

// File: rtl/pixel_stream_arbiter.sv
// RGB/gray source arbiter with per-port write FIFOs and sticky overflow.
// Optional macro ARB_GRAY_PACK_EN packs two gray pixels per port-1 word.
module pixel_stream_arbiter #(
   parameter int PIX_W      = 8,
   parameter int NUM_GRAY   = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int SEL_W      = 3
) (
   input logic iClk,
   input logic iRst_n,
   pixel_stream_arbiter_if.slave bus
);
   localparam int DW = 2 * PIX_W;
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   logic [SEL_W-1:0]   mode_q;
   logic [SEL_W-1:0]   eff;
   logic               racc;
   logic               gacc;
   logic [PIX_W-1:0]   gpix;
   logic [1:0]         push;
   logic [1:0]         rdy;
   logic [1:0]         vld;
   logic [1:0]         ovf_set;
   logic [1:0][DW-1:0] wd;
   logic [1:0][DW-1:0] rd;
   logic [1:0]         ovf_q;

   // The frame-start cycle already uses the newly requested mode.
   always_comb begin
      eff  = bus.iFrame_start ? bus.iSelect : mode_q;
      racc = (eff == SEL_W'(1)) && bus.iRGB_valid;
      gacc = 1'b0;
      gpix = '0;
      for (int k = 0; k < NUM_GRAY; k++) begin
         if (eff == SEL_W'(k + 2)) begin
            gacc = bus.iGray_valid[k];
            gpix = bus.iGray[k*PIX_W +: PIX_W];
         end
      end
   end

   always_ff @(posedge iClk) begin
      if (!iRst_n) mode_q <= '0;
      else if (bus.iFrame_start) mode_q <= bus.iSelect;
   end

`ifdef ARB_GRAY_PACK_EN
   logic             phase_q;
   logic             phase_eff;
   logic [PIX_W-1:0] p0_q;

   assign phase_eff = phase_q && !bus.iFrame_start;

   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         phase_q <= 1'b0;
         p0_q    <= '0;
      end else if (gacc) begin
         phase_q <= !phase_eff;
         if (!phase_eff) p0_q <= gpix;
      end else if (bus.iFrame_start) begin
         phase_q <= 1'b0;
      end
   end
`endif

   always_comb begin
      push = 2'b00;
      wd   = '0;
      if (racc) begin
         push  = 2'b11;
         wd[0] = {bus.iRGB_R, bus.iRGB_G};
         wd[1] = {bus.iRGB_B, {PIX_W{1'b0}}};
      end else if (gacc) begin
`ifdef ARB_GRAY_PACK_EN
         if (phase_eff) begin
            push[0] = 1'b1;
            wd[0]   = {gpix, p0_q};
         end
`else
         push  = 2'b11;
         wd[0] = {gpix, gpix};
         wd[1] = {gpix, gpix};
`endif
      end
   end

   assign rdy = {bus.iWr2_ready, bus.iWr1_ready};

   for (genvar p = 0; p < 2; p++) begin : g_fifo
      logic [DW-1:0] mem [FIFO_DEPTH];
      logic [AW-1:0] rp;
      logic [AW-1:0] wp;
      logic [AW:0]   cnt;
      logic          full;
      logic          pop;
      logic          wr;

      assign full       = cnt == (AW+1)'(FIFO_DEPTH);
      assign vld[p]     = cnt != '0;
      assign pop        = vld[p] && rdy[p];
      // A full FIFO still takes the word when its head leaves this cycle.
      assign wr         = push[p] && (!full || pop);
      assign ovf_set[p] = push[p] && full && !pop;
      assign rd[p]      = vld[p] ? mem[rp] : '0;

      always_ff @(posedge iClk) begin
         if (wr) mem[wp] <= wd[p];
      end

      always_ff @(posedge iClk) begin
         if (!iRst_n) begin
            rp  <= '0;
            wp  <= '0;
            cnt <= '0;
         end else begin
            if (pop) rp <= rp + AW'(1);
            if (wr) wp <= wp + AW'(1);
            cnt <= cnt + (AW+1)'(wr) - (AW+1)'(pop);
         end
      end
   end

   always_ff @(posedge iClk) begin
      if (!iRst_n) ovf_q <= 2'b00;
      else ovf_q <= (bus.iClear_ovf ? 2'b00 : ovf_q) | ovf_set;
   end

   assign bus.oWr1_valid = vld[0];
   assign bus.oWr2_valid = vld[1];
   assign bus.oWr1_data  = rd[0];
   assign bus.oWr2_data  = rd[1];
   assign bus.oMode      = mode_q;
   assign bus.oOverflow  = ovf_q;
endmodule

// File: tb/tb_pixel_stream_arbiter.sv
// Randomized self-checking bench for pixel_stream_arbiter against a
// queue-based reference model.
module tb_pixel_stream_arbiter;
   localparam int PW = 8;
   localparam int NG = 2;
   localparam int DEPTH = 4;
   localparam int SW = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int total = 0;
   int bad = 0;

   logic [15:0] q1[$];
   logic [15:0] q2[$];
   logic [2:0]  m_mode;
   logic [1:0]  m_ovf;
   bit          m_phase;
   logic [7:0]  m_p0;

   always #5 clk = ~clk;

   pixel_stream_arbiter_if #(.PIX_W(PW), .NUM_GRAY(NG), .SEL_W(SW)) bus ();

   pixel_stream_arbiter #(
      .PIX_W(PW), .NUM_GRAY(NG), .FIFO_DEPTH(DEPTH), .SEL_W(SW)
   ) dut (
      .iClk(clk),
      .iRst_n(rst_n),
      .bus(bus)
   );

   function automatic logic [38:0] expv();
      logic [15:0] h1;
      logic [15:0] h2;
      h1 = (q1.size() != 0) ? q1[0] : 16'h0;
      h2 = (q2.size() != 0) ? q2[0] : 16'h0;
      return {q1.size() != 0, h1, q2.size() != 0, h2, m_mode, m_ovf};
   endfunction

   function automatic logic [38:0] actv();
      return {bus.oWr1_valid, bus.oWr1_data, bus.oWr2_valid,
              bus.oWr2_data, bus.oMode, bus.oOverflow};
   endfunction

   // Model one clock from the currently driven inputs, then step the DUT.
   task automatic cyc();
      logic [2:0]  eff;
      logic [15:0] a;
      logic [15:0] b;
      logic [7:0]  g;
      bit ra, ga, pu1, pu2, pop1, pop2;
      logic [1:0] set;
      a = 0; b = 0; g = 0; ga = 0; pu1 = 0; pu2 = 0; set = 0;
      if (!rst_n) begin
         q1.delete(); q2.delete();
         m_mode = 0; m_ovf = 0; m_phase = 0; m_p0 = 0;
      end else begin
         eff = bus.iFrame_start ? bus.iSelect : m_mode;
         ra = (eff == 1) && bus.iRGB_valid;
         if (eff >= 2 && int'(eff) <= NG + 1) begin
            ga = bus.iGray_valid[eff-2];
            g  = bus.iGray[(eff-2)*PW +: PW];
         end
         if (bus.iFrame_start) m_phase = 0;
         if (ra) begin
            a = {bus.iRGB_R, bus.iRGB_G};
            b = {bus.iRGB_B, 8'h00};
            pu1 = 1; pu2 = 1;
         end else if (ga) begin
`ifdef ARB_GRAY_PACK_EN
            if (!m_phase) begin
               m_p0 = g; m_phase = 1;
            end else begin
               a = {g, m_p0}; pu1 = 1; m_phase = 0;
            end
`else
            a = {g, g}; b = {g, g}; pu1 = 1; pu2 = 1;
`endif
         end
         pop1 = bus.iWr1_ready && q1.size() != 0;
         pop2 = bus.iWr2_ready && q2.size() != 0;
         if (pop1) void'(q1.pop_front());
         if (pop2) void'(q2.pop_front());
         if (pu1) begin
            if (q1.size() < DEPTH) q1.push_back(a);
            else set[0] = 1;
         end
         if (pu2) begin
            if (q2.size() < DEPTH) q2.push_back(b);
            else set[1] = 1;
         end
         m_ovf = (bus.iClear_ovf ? 2'b00 : m_ovf) | set;
         if (bus.iFrame_start) m_mode = bus.iSelect;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.iSelect = 0; bus.iFrame_start = 0;
      bus.iRGB_valid = 0; bus.iRGB_R = 0; bus.iRGB_G = 0; bus.iRGB_B = 0;
      bus.iGray_valid = 0; bus.iGray = 0;
      bus.iWr1_ready = 1; bus.iWr2_ready = 1; bus.iClear_ovf = 0;
   endtask

   task automatic test_reset();
      rst_n = 0;
      for (int i = 0; i < 6; i++) begin
         bus.iSelect = SW'($urandom);
         bus.iFrame_start = 1'($urandom);
         bus.iRGB_valid = 1'($urandom);
         bus.iRGB_R = 8'($urandom);
         bus.iGray_valid = NG'($urandom);
         bus.iGray = 16'($urandom);
         bus.iWr1_ready = 1'($urandom);
         bus.iWr2_ready = 1'($urandom);
         cyc();
         total++;
         if ({bus.oMode, bus.oWr1_valid, bus.oWr2_valid, bus.oOverflow,
              bus.oWr1_data, bus.oWr2_data} !== 39'h0) begin
            bad++;
            $display("FAIL reset cyc%0d got mode=%0d v=%b%b ovf=%b want all 0",
                     i, bus.oMode, bus.oWr1_valid, bus.oWr2_valid, bus.oOverflow);
         end
      end
      idle_inputs();
      rst_n = 1;
   endtask

   task automatic test_rgb();
      bus.iSelect = 1; bus.iFrame_start = 1; bus.iRGB_valid = 1;
      bus.iRGB_R = 255; bus.iRGB_G = 255; bus.iRGB_B = 255;
      cyc();
      total++;
      if ({bus.oWr1_valid, bus.oWr1_data, bus.oWr2_valid, bus.oWr2_data}
          !== {1'b1, 16'hFFFF, 1'b1, 16'hFF00}) begin
         bad++;
         $display("FAIL rgb_white got %b %h %b %h want 1 ffff 1 ff00",
                  bus.oWr1_valid, bus.oWr1_data, bus.oWr2_valid, bus.oWr2_data);
      end
      bus.iFrame_start = 0; bus.iRGB_valid = 0; bus.iRGB_R = 100;
      cyc();
      total++;
      if ({bus.oWr1_valid, bus.oWr2_valid, bus.oMode} !== {2'b00, 3'd1}) begin
         bad++;
         $display("FAIL rgb_novalid got v=%b%b mode=%0d want v=00 mode=1",
                  bus.oWr1_valid, bus.oWr2_valid, bus.oMode);
      end
      total++;
      if (actv() !== expv()) begin
         bad++;
         $display("FAIL rgb_model got %h want %h", actv(), expv());
      end
   endtask

   task automatic test_mode_boundary();
      bus.iSelect = 2; bus.iGray_valid = 2'b01; bus.iGray = 16'h005A;
      for (int i = 0; i < 3; i++) begin
         cyc();
         total++;
         if ({bus.oWr1_valid, bus.oWr2_valid, bus.oMode} !== {2'b00, 3'd1}) begin
            bad++;
            $display("FAIL gray_before_fs cyc%0d got v=%b%b mode=%0d want 00 1",
                     i, bus.oWr1_valid, bus.oWr2_valid, bus.oMode);
         end
      end
      bus.iFrame_start = 1;
      cyc();
      bus.iFrame_start = 0; bus.iGray_valid = 0;
`ifndef ARB_GRAY_PACK_EN
      total++;
      if ({bus.oWr1_valid, bus.oWr1_data, bus.oWr2_valid, bus.oWr2_data}
          !== {1'b1, 16'h5A5A, 1'b1, 16'h5A5A}) begin
         bad++;
         $display("FAIL gray_at_fs got %b %h %b %h want 1 5a5a 1 5a5a",
                  bus.oWr1_valid, bus.oWr1_data, bus.oWr2_valid, bus.oWr2_data);
      end
`endif
      total++;
      if (actv() !== expv()) begin
         bad++;
         $display("FAIL gray_fs_model got %h want %h", actv(), expv());
      end
      cyc();
   endtask

   task automatic test_overflow();
      bus.iSelect = 1; bus.iFrame_start = 1; bus.iRGB_valid = 1;
      bus.iWr1_ready = 1; bus.iWr2_ready = 0;
      for (int i = 0; i < DEPTH + 1; i++) begin
         bus.iRGB_R = 8'(16 + i); bus.iRGB_G = 8'(32 + i); bus.iRGB_B = 8'(48 + i);
         cyc();
         bus.iFrame_start = 0;
         total++;
         if (actv() !== expv()) begin
            bad++;
            $display("FAIL ovf_fill cyc%0d got %h want %h", i, actv(), expv());
         end
      end
      bus.iRGB_valid = 0;
      total++;
      if ({bus.oOverflow, bus.oWr2_valid, bus.oWr2_data} !== {2'b10, 1'b1, 16'h3000}) begin
         bad++;
         $display("FAIL ovf_flag got ovf=%b v2=%b d2=%h want 10 1 3000",
                  bus.oOverflow, bus.oWr2_valid, bus.oWr2_data);
      end
      bus.iClear_ovf = 1;
      cyc();
      bus.iClear_ovf = 0;
      total++;
      if (bus.oOverflow !== 2'b00) begin
         bad++;
         $display("FAIL ovf_clear got %b want 00", bus.oOverflow);
      end
   endtask

   task automatic test_full_pushpop();
      bus.iRGB_valid = 1; bus.iWr2_ready = 1;
      bus.iRGB_R = 8'h77; bus.iRGB_G = 8'h88; bus.iRGB_B = 8'h99;
      cyc();
      bus.iRGB_valid = 0;
      total++;
      if (bus.oOverflow !== 2'b00) begin
         bad++;
         $display("FAIL full_pushpop_ovf got %b want 00", bus.oOverflow);
      end
      for (int i = 0; i < DEPTH + 1; i++) begin
         total++;
         if (actv() !== expv()) begin
            bad++;
            $display("FAIL full_drain cyc%0d got %h want %h", i, actv(), expv());
         end
         cyc();
      end
   endtask

`ifdef ARB_GRAY_PACK_EN
   task automatic test_pack();
      logic [7:0]  px[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      bit          fsv[5] = '{1, 0, 0, 1, 0};
      bit          seen2 = 0;
      bus.iSelect = 2; bus.iGray_valid = 2'b01;
      bus.iWr1_ready = 1; bus.iWr2_ready = 1;
      for (int i = 0; i < 5; i++) begin
         bus.iFrame_start = fsv[i];
         bus.iGray = {8'h00, px[i]};
         cyc();
         if (bus.oWr2_valid) seen2 = 1;
         total++;
         if (actv() !== expv()) begin
            bad++;
            $display("FAIL pack_model cyc%0d got %h want %h", i, actv(), expv());
         end
         if (i == 1 || i == 4) begin
            total++;
            if ({bus.oWr1_valid, bus.oWr1_data} !== {1'b1, (i == 1) ? 16'h2211 : 16'h5544}) begin
               bad++;
               $display("FAIL pack_word cyc%0d got %b %h", i, bus.oWr1_valid, bus.oWr1_data);
            end
         end else begin
            total++;
            if (bus.oWr1_valid !== 1'b0) begin
               bad++;
               $display("FAIL pack_noword cyc%0d got v1=%b want 0", i, bus.oWr1_valid);
            end
         end
      end
      bus.iFrame_start = 0; bus.iGray_valid = 0;
      cyc();
      total++;
      if (seen2 || bus.oWr2_valid !== 1'b0) begin
         bad++;
         $display("FAIL pack_port2 got seen=%b want 0", seen2);
      end
   endtask
`endif

   task automatic test_random();
      for (int i = 0; i < 500; i++) begin
         rst_n = ($urandom_range(0, 149) != 0);
         bus.iFrame_start = ($urandom_range(0, 9) == 0);
         bus.iSelect = SW'($urandom);
         bus.iRGB_valid = 1'($urandom);
         bus.iRGB_R = 8'($urandom);
         bus.iRGB_G = 8'($urandom);
         bus.iRGB_B = 8'($urandom);
         bus.iGray_valid = NG'($urandom);
         bus.iGray = 16'($urandom);
         bus.iWr1_ready = ($urandom_range(0, 3) != 0);
         bus.iWr2_ready = ($urandom_range(0, 2) == 0);
         bus.iClear_ovf = ($urandom_range(0, 15) == 0);
         cyc();
         total++;
         if (actv() !== expv()) begin
            bad++;
            $display("FAIL random cyc%0d got %h want %h", i, actv(), expv());
         end
      end
      rst_n = 1;
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      m_mode = 0; m_ovf = 0; m_phase = 0; m_p0 = 0;
      test_reset();
      test_rgb();
      test_mode_boundary();
      test_overflow();
      test_full_pushpop();
`ifdef ARB_GRAY_PACK_EN
      test_pack();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
